fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register. Holds the PC, drives the instruction-memory address
//  and latches {instr, PC+2, valid} into IF/ID for decode. Accepts the resolved branch (branch_taken, PC_branch)
//  from the branch control unit in ID. Static predict-not-taken; a taken branch flushes the one wrong-path fetch.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  NOP_INSTR  16'h0000  instruction word inserted into IF/ID on flush/reset (ADD $0,$0,$0)
//  HLT_OPC    4'hF      opcode (instr[15:12]) that halts fetch
// PORTS
//  clk            in   1   system clock, single clock domain, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  stall          in   1   hazard unit: hold PC and IF/ID
//  branch_taken   in   1   from branch control (ID): redirect fetch
//  PC_branch      in   16  branch target from branch control
//  imem_addr      out  16  instruction memory address (= PC, combinational)
//  imem_data      in   16  instruction word, combinational read of imem_addr
//  IF_ID_instr    out  16  registered instruction
//  IF_ID_PC_next  out  16  registered PC+2 of that instruction (feeds branch PC_next)
//  IF_ID_valid    out  1   IF/ID holds a real instruction
//  fetch_halted   out  1   HLT fetched; PC frozen
//  fetch_cnt      out  16  instructions fetched (stats, see CONFIGURATION)
//  flush_cnt      out  16  IF/ID flushes (stats)
// BEHAVIOUR
//  Reset (async, rst_n=0): PC=RESET_PC, IF_ID_instr=NOP_INSTR, IF_ID_PC_next=0, IF_ID_valid=0,
//   fetch_halted=0, counters=0. First fetch at RESET_PC on first rising edge after deassert.
//  PC_plus2 = PC + 2, 16-bit modulo (16'hFFFE -> 16'h0000, no flag). PC[0] always 0; PC_branch[0] ignored.
//  Next-state priority per edge (highest first):
//   1 branch_taken: PC<={PC_branch[15:1],0}; IF/ID<={NOP_INSTR,0,valid=0} (flush); fetch_halted<=0.
//   2 stall: PC, IF/ID, fetch_halted hold.
//   3 fetch_halted: PC holds; IF/ID<=NOP bubble (valid=0).
//   4 normal: IF/ID<={imem_data, PC_plus2, 1}; PC<=PC_plus2, except if imem_data[15:12]==HLT_OPC then
//     PC holds and fetch_halted<=1 (HLT itself enters IF/ID with valid=1).
//  branch_taken with stall same cycle: branch wins (stall of the wrong-path fetch is moot).
//  HLT fetched in branch shadow is squashed by the flush and fetch_halted cleared (case 1).
//  Latency: imem_data at PC visible on IF_ID_* one cycle later; taken branch -> target in IF_ID 2 edges later.
//  Stall duration unbounded; IF_ID_* stable bit-for-bit throughout.
// CONFIGURATION
//  FETCH_STATS_EN defined: fetch_cnt +1 on each case-4 edge (incl. HLT); flush_cnt +1 on each case-1 edge;
//   both saturate at 16'hFFFF; cleared only by reset.
//  Not defined: fetch_cnt, flush_cnt tied to 16'h0000; no counter flops synthesised.
// STRUCTURE
//  Shared defs header cpu_defs.vh: opcode constants (HLT_OPC), NOP_INSTR, RESET_PC, instr field ranges.
//  PC+2 uses the existing 16-bit CLA (sub=0). One sub-module: if_id_reg (instr/PC_next/valid flops with
//  async reset, wen=~stall, flush input) reused later for ID/EX-style stage registers.
// TESTING
//  Reset mid-run at PC=16'h0010 -> same cycle PC=0, IF_ID_valid=0, instr=16'h0000, counters=0.
//  Sequential imem 0x0:A000,0x2:A001,0x4:A002 -> IF_ID_instr A000/A001/A002 with PC_next 2/4/6, valid=1.
//  stall held 3 cycles at PC=16'h0004 -> imem_addr, IF_ID_* unchanged; resume fetches 0x0004 next edge.
//  branch_taken=1,PC_branch=16'h0041 with stall=1 -> PC=16'h0040, IF_ID_valid=0, flush_cnt=1 (STATS on).
//  HLT (F000) at 0x0008 -> IF_ID_instr=F000 valid=1, then PC stays 0x0008, bubbles, fetch_halted=1;
//   branch_taken to 0x0020 same period -> fetch_halted=0, fetch resumes at 0x0020.
//  PC=16'hFFFE, no branch -> next PC=16'h0000, IF_ID_PC_next=16'h0000; stats build off -> counters stay 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset/NOP/HLT constants, instruction fields, IF/ID record, adder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package fetch_stage_pkg;

    typedef logic [15:0] word_t;

    // Instruction field ranges
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam word_t      RESET_PC_DEF  = 16'h0000;
    localparam word_t      NOP_INSTR_DEF = 16'h0000;   // ADD $0,$0,$0
    localparam logic [3:0] HLT_OPC_DEF   = 4'hF;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        word_t instr;
        word_t pc_next;
        logic  valid;
    } if_id_t;

    // 16-bit carry-lookahead add/subtract (sub=1 gives a-b). Carry out is
    // dropped, so the result wraps modulo 2^16.
    function automatic word_t cla_add16(input word_t a, input word_t b, input logic sub);
        word_t       bb;
        word_t       g;
        word_t       p;
        logic [15:0] c;
        bb   = sub ? ~b : b;
        g    = a & bb;
        p    = a ^ bb;
        c[0] = sub;
        for (int i = 0; i < 15; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch inputs, instruction-memory port, IF/ID outputs and stats.
// Latency: n/a (wiring only).
// Backpressure: stall holds the stage; master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  stall;
    logic  branch_taken;
    word_t PC_branch;
    word_t imem_addr;
    word_t imem_data;
    word_t IF_ID_instr;
    word_t IF_ID_PC_next;
    logic  IF_ID_valid;
    logic  fetch_halted;
    word_t fetch_cnt;
    word_t flush_cnt;

    modport master (
        input  stall, branch_taken, PC_branch, imem_data,
        output imem_addr, IF_ID_instr, IF_ID_PC_next, IF_ID_valid,
               fetch_halted, fetch_cnt, flush_cnt
    );

    modport slave (
        output stall, branch_taken, PC_branch, imem_data,
        input  imem_addr, IF_ID_instr, IF_ID_PC_next, IF_ID_valid,
               fetch_halted, fetch_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline stage register {instr, pc_next, valid} with write enable and flush.
// Latency: 1 cycle from *_i to *_o.
// Backpressure: wen_i=0 holds contents bit-for-bit; flush_i loads a NOP bubble and overrides wen_i.
// Ports: clk, rst_n (async, active low); wen_i, flush_i; instr_i/pc_next_i/valid_i in; instr_o/pc_next_o/valid_o out.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wen_i,
    input  logic  flush_i,
    input  word_t instr_i,
    input  word_t pc_next_i,
    input  logic  valid_i,
    output word_t instr_o,
    output word_t pc_next_o,
    output logic  valid_o
);

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc_next: 16'h0000, valid: 1'b0};

    if_id_t stage_q;
    if_id_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = BUBBLE;
        end else if (wen_i) begin
            stage_d = '{instr: instr_i, pc_next: pc_next_i, valid: valid_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign instr_o   = stage_q.instr;
    assign pc_next_o = stage_q.pc_next;
    assign valid_o   = stage_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: PC, imem address, static not-taken prediction, HLT freeze.
// Latency: imem_data at PC appears on IF_ID_* one edge later; taken branch target reaches IF/ID two edges later.
// Backpressure: stall holds PC, IF/ID and halt state indefinitely; a taken branch overrides stall.
// Ports: clk, rst_n (async, active low); bus (fetch_stage_if.master): stall, branch_taken, PC_branch,
//        imem_data in; imem_addr, IF_ID_instr, IF_ID_PC_next, IF_ID_valid, fetch_halted, fetch_cnt, flush_cnt out.
// Build option: define FETCH_STATS_EN for saturating fetch/flush counters; otherwise both read 0.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t      RESET_PC  = RESET_PC_DEF,
    parameter word_t      NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [3:0] HLT_OPC   = HLT_OPC_DEF
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);

    word_t pc_q;
    word_t pc_d;
    logic  halted_q;
    logic  halted_d;
    word_t pc_plus2;
    word_t pc_target;
    logic  is_hlt;
    logic  do_flush;
    logic  do_fetch;
    logic  ifid_flush;

    assign pc_plus2  = cla_add16(pc_q, 16'h0002, 1'b0);
    // Bit 0 of the target is ignored: instructions are halfword aligned.
    assign pc_target = bus.PC_branch & 16'hFFFE;
    assign is_hlt    = (bus.imem_data[OPC_MSB:OPC_LSB] == HLT_OPC);

    // Priority: branch > stall > halted > normal fetch.
    assign do_flush   = bus.branch_taken;
    assign do_fetch   = !bus.branch_taken && !bus.stall && !halted_q;
    // While halted (and not stalled) IF/ID is refilled with bubbles.
    assign ifid_flush = do_flush || (!bus.stall && halted_q);

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (do_flush) begin
            pc_d     = pc_target;
            halted_d = 1'b0;
        end else if (do_fetch) begin
            // HLT itself is passed to decode, but the PC stops on it.
            if (is_hlt) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_plus2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC & 16'hFFFE;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.fetch_halted = halted_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen_i     (do_fetch),
        .flush_i   (ifid_flush),
        .instr_i   (bus.imem_data),
        .pc_next_i (pc_plus2),
        .valid_i   (1'b1),
        .instr_o   (bus.IF_ID_instr),
        .pc_next_o (bus.IF_ID_PC_next),
        .valid_o   (bus.IF_ID_valid)
    );

`ifdef FETCH_STATS_EN
    word_t fetch_cnt_q;
    word_t fetch_cnt_d;
    word_t flush_cnt_q;
    word_t flush_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_fetch && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 16'h0001;
        end
        if (do_flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.fetch_cnt = 16'h0000;
    assign bus.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-edge vector table plus wrap-around and mid-run reset sequences.
// Latency: expectations sampled 1 time unit after each rising edge.
// Backpressure: stall, branch-over-stall and HLT freeze exercised in the table.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs applied before an edge, expected outputs just after it.
    // Counter columns give the values with stats enabled.
    typedef struct {
        logic  stall;
        logic  br;
        word_t pc_br;
        word_t imem;
        word_t e_addr;
        word_t e_instr;
        word_t e_pcn;
        logic  e_valid;
        logic  e_halt;
        word_t e_fcnt;
        word_t e_flcnt;
    } vec_t;

    vec_t vt[14];

    initial begin
        // stall br  pc_br     imem      addr      instr     pcn       v     h     fcnt flcnt
        vt[0]  = '{1'b0, 1'b0, 16'h0000, 16'hA000, 16'h0002, 16'hA000, 16'h0002, 1'b1, 1'b0, 16'd1, 16'd0};
        vt[1]  = '{1'b0, 1'b0, 16'h0000, 16'hA001, 16'h0004, 16'hA001, 16'h0004, 1'b1, 1'b0, 16'd2, 16'd0};
        vt[2]  = '{1'b1, 1'b0, 16'h0000, 16'hA002, 16'h0004, 16'hA001, 16'h0004, 1'b1, 1'b0, 16'd2, 16'd0};
        vt[3]  = '{1'b1, 1'b0, 16'h0000, 16'hA002, 16'h0004, 16'hA001, 16'h0004, 1'b1, 1'b0, 16'd2, 16'd0};
        vt[4]  = '{1'b1, 1'b0, 16'h0000, 16'hA002, 16'h0004, 16'hA001, 16'h0004, 1'b1, 1'b0, 16'd2, 16'd0};
        vt[5]  = '{1'b0, 1'b0, 16'h0000, 16'hA002, 16'h0006, 16'hA002, 16'h0006, 1'b1, 1'b0, 16'd3, 16'd0};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 16'hA003, 16'h0008, 16'hA003, 16'h0008, 1'b1, 1'b0, 16'd4, 16'd0};
        // HLT at 0x0008
        vt[7]  = '{1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0008, 16'hF000, 16'h000A, 1'b1, 1'b1, 16'd5, 16'd0};
        vt[8]  = '{1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0008, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'd5, 16'd0};
        // branch out of halt
        vt[9]  = '{1'b0, 1'b1, 16'h0020, 16'hF000, 16'h0020, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd5, 16'd1};
        vt[10] = '{1'b0, 1'b0, 16'h0000, 16'hA010, 16'h0022, 16'hA010, 16'h0022, 1'b1, 1'b0, 16'd6, 16'd1};
        // branch with stall, odd target
        vt[11] = '{1'b1, 1'b1, 16'h0041, 16'hA011, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd6, 16'd2};
        vt[12] = '{1'b0, 1'b0, 16'h0000, 16'hA020, 16'h0042, 16'hA020, 16'h0042, 1'b1, 1'b0, 16'd7, 16'd2};
        // HLT in branch shadow is squashed
        vt[13] = '{1'b0, 1'b1, 16'h0060, 16'hF000, 16'h0060, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd7, 16'd3};

        rst_n            = 1'b0;
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.PC_branch    = 16'h0000;
        bus.imem_data    = 16'h0000;
        #2;
        chk("rst_addr",   32'(bus.imem_addr),     32'h0);
        chk("rst_instr",  32'(bus.IF_ID_instr),   32'h0);
        chk("rst_pcn",    32'(bus.IF_ID_PC_next), 32'h0);
        chk("rst_valid",  32'(bus.IF_ID_valid),   32'h0);
        chk("rst_halt",   32'(bus.fetch_halted),  32'h0);
        chk("rst_fcnt",   32'(bus.fetch_cnt),     32'h0);
        chk("rst_flcnt",  32'(bus.flush_cnt),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bus.stall        = vt[i].stall;
            bus.branch_taken = vt[i].br;
            bus.PC_branch    = vt[i].pc_br;
            bus.imem_data    = vt[i].imem;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_addr", i),  32'(bus.imem_addr),     32'(vt[i].e_addr));
            chk($sformatf("v%0d_instr", i), 32'(bus.IF_ID_instr),   32'(vt[i].e_instr));
            chk($sformatf("v%0d_pcn", i),   32'(bus.IF_ID_PC_next), 32'(vt[i].e_pcn));
            chk($sformatf("v%0d_valid", i), 32'(bus.IF_ID_valid),   32'(vt[i].e_valid));
            chk($sformatf("v%0d_halt", i),  32'(bus.fetch_halted),  32'(vt[i].e_halt));
            chk($sformatf("v%0d_fcnt", i),  32'(bus.fetch_cnt),     STATS ? 32'(vt[i].e_fcnt)  : 32'h0);
            chk($sformatf("v%0d_flcnt", i), 32'(bus.flush_cnt),     STATS ? 32'(vt[i].e_flcnt) : 32'h0);
        end

        // PC wrap: branch to 0xFFFE, then one sequential fetch.
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b1;
        bus.PC_branch    = 16'hFFFE;
        bus.imem_data    = 16'hA0FE;
        @(posedge clk);
        #1;
        chk("wrap_br_addr", 32'(bus.imem_addr), 32'hFFFE);
        bus.branch_taken = 1'b0;
        bus.imem_data    = 16'hA0FF;
        @(posedge clk);
        #1;
        chk("wrap_addr",  32'(bus.imem_addr),     32'h0000);
        chk("wrap_pcn",   32'(bus.IF_ID_PC_next), 32'h0000);
        chk("wrap_instr", 32'(bus.IF_ID_instr),   32'hA0FF);
        chk("wrap_valid", 32'(bus.IF_ID_valid),   32'h1);
        chk("wrap_fcnt",  32'(bus.fetch_cnt),     STATS ? 32'd8 : 32'h0);
        chk("wrap_flcnt", 32'(bus.flush_cnt),     STATS ? 32'd4 : 32'h0);

        // Walk to 0x0010, then pull reset in mid-cycle.
        for (int i = 0; i < 8; i++) begin
            bus.imem_data = 16'hA100 + 16'(i);
            @(posedge clk);
            #1;
        end
        chk("pre_rst_addr",  32'(bus.imem_addr),   32'h0010);
        chk("pre_rst_instr", 32'(bus.IF_ID_instr), 32'hA107);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr",  32'(bus.imem_addr),     32'h0);
        chk("mid_rst_valid", 32'(bus.IF_ID_valid),   32'h0);
        chk("mid_rst_instr", 32'(bus.IF_ID_instr),   32'h0);
        chk("mid_rst_pcn",   32'(bus.IF_ID_PC_next), 32'h0);
        chk("mid_rst_fcnt",  32'(bus.fetch_cnt),     32'h0);
        chk("mid_rst_flcnt", 32'(bus.flush_cnt),     32'h0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.imem_data = 16'hA200;
        @(posedge clk);
        #1;
        chk("post_rst_addr",  32'(bus.imem_addr),   32'h0002);
        chk("post_rst_instr", 32'(bus.IF_ID_instr), 32'hA200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
